// File: rtl/pc_next_unit.sv
// rtl/pc_next_unit.sv - registered program counter with stall buffer, interrupt latch and EPC capture
module pc_next_unit #(
    parameter int          WIDTH     = 32,
    parameter logic [31:0] RESET_VEC = 32'h8000_0000,
    parameter logic [31:0] INT_VEC   = 32'h8000_0004,
    parameter logic [31:0] EXC_VEC   = 32'h8000_0008,
    parameter int          PC_STEP   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             iStall,
    input  logic [2:0]       iPCSrc,
    input  logic             iBranch,
    input  logic [WIDTH-1:0] iJumpTgt,
    input  logic [WIDTH-1:0] iJumpReg,
    input  logic [WIDTH-1:0] iBranchTarget,
    input  logic             iIntReq,
    output logic [WIDTH-1:0] oPC,
    output logic [WIDTH-1:0] oPC_plus_4,
    output logic [WIDTH-1:0] oEPC,
    output logic             oIntPending,
    output logic             oRedirect
);

    localparam logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_VEC);
    localparam logic [WIDTH-1:0] INT_PC   = WIDTH'(INT_VEC);
    localparam logic [WIDTH-1:0] EXC_PC   = WIDTH'(EXC_VEC);
    localparam logic [WIDTH-1:0] STEP     = WIDTH'(PC_STEP);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HOLD,
        ST_HOLD_PEND
    } state_t;

    typedef enum logic [2:0] {
        K_J,
        K_JR,
        K_BR,
        K_INT,
        K_EXC
    } kind_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic             pend_q, pend_d;
    logic             redir_q, redir_d;
    logic [WIDTH-1:0] buf_tgt_q, buf_tgt_d;
    kind_t            buf_kind_q, buf_kind_d;

    logic             live_exc, live_int, live_br, live_j, live_jr, live_nonseq;
    kind_t            live_kind;
    logic [WIDTH-1:0] live_tgt;
    logic [WIDTH-1:0] seq_pc;
    logic [WIDTH-1:0] base_pc;
    logic             base_seq;
    logic             buf_valid, exc_win, int_win;

    assign seq_pc      = pc_q + STEP;
    assign oPC         = pc_q;
    assign oPC_plus_4  = seq_pc;
    assign oEPC        = epc_q;
    assign oIntPending = pend_q;
    assign oRedirect   = redir_q;

    // Decode the live request into a single kind/target pair (only one can be active per cycle)
    always_comb begin
        live_exc    = (iPCSrc == 3'b011);
        live_int    = (iPCSrc == 3'b101);
        live_br     = (iPCSrc == 3'b100) && iBranch;
        live_j      = (iPCSrc == 3'b001);
        live_jr     = (iPCSrc == 3'b010);
        live_nonseq = live_exc | live_int | live_br | live_j | live_jr;
        live_kind   = K_J;
        live_tgt    = iJumpTgt;
        if (live_exc) begin
            live_kind = K_EXC;
            live_tgt  = EXC_PC;
        end else if (live_int) begin
            live_kind = K_INT;
            live_tgt  = INT_PC;
        end else if (live_br) begin
            live_kind = K_BR;
            live_tgt  = iBranchTarget;
        end else if (live_jr) begin
            live_kind = K_JR;
            live_tgt  = iJumpReg;
        end
    end

    // Next-state, next-PC, buffer and interrupt-latch selection
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        epc_d      = epc_q;
        pend_d     = pend_q | iIntReq;
        redir_d    = 1'b0;
        buf_tgt_d  = buf_tgt_q;
        buf_kind_d = buf_kind_q;
        buf_valid  = (state_q == ST_HOLD_PEND);
        exc_win    = 1'b0;
        int_win    = 1'b0;
        base_pc    = seq_pc;
        base_seq   = 1'b1;

        if (iStall) begin
            if (!buf_valid) begin
                if (live_nonseq) begin
                    buf_tgt_d  = live_tgt;
                    buf_kind_d = live_kind;
                    state_d    = ST_HOLD_PEND;
                end else begin
                    state_d    = ST_HOLD;
                end
            end else if (live_exc && (buf_kind_q != K_EXC)) begin
                // An exception must never be lost behind an older, weaker redirect
                buf_tgt_d  = EXC_PC;
                buf_kind_d = K_EXC;
            end
        end else begin
            state_d = ST_RUN;
            exc_win = live_exc || (buf_valid && (buf_kind_q == K_EXC));
            if (buf_valid) begin
                int_win = pend_q || (buf_kind_q == K_INT);
                if ((buf_kind_q == K_J) || (buf_kind_q == K_JR) || (buf_kind_q == K_BR)) begin
                    base_pc  = buf_tgt_q;
                    base_seq = 1'b0;
                end
            end else begin
                int_win = pend_q || live_int;
                if (live_br) begin
                    base_pc  = iBranchTarget;
                    base_seq = 1'b0;
                end else if (live_j) begin
                    base_pc  = iJumpTgt;
                    base_seq = 1'b0;
                end else if (live_jr) begin
                    base_pc  = iJumpReg;
                    base_seq = 1'b0;
                end
            end

            if (exc_win) begin
                pc_d    = EXC_PC;
                epc_d   = pc_q;
                redir_d = 1'b1;
            end else if (int_win) begin
                // The resume point is whatever would have loaded had the interrupt not been taken
                pc_d    = INT_PC;
                epc_d   = base_pc;
                redir_d = 1'b1;
                pend_d  = iIntReq;
            end else begin
                pc_d    = base_pc;
                redir_d = !base_seq;
            end
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            epc_q      <= '0;
            pend_q     <= 1'b0;
            redir_q    <= 1'b0;
            buf_tgt_q  <= '0;
            buf_kind_q <= K_J;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            pend_q     <= pend_d;
            redir_q    <= redir_d;
            buf_tgt_q  <= buf_tgt_d;
            buf_kind_q <= buf_kind_d;
        end
    end

endmodule

// File: tb/tb_pc_next_unit.sv
// tb/tb_pc_next_unit.sv - directed self-checking bench for pc_next_unit
module tb_pc_next_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [2:0]  pcsrc;
    logic        branch;
    logic [31:0] jtgt, jreg, btgt;
    logic        intreq;

    logic [31:0] pc32, pc4_32, epc32;
    logic        pend32, redir32;
    logic [15:0] pc16, pc4_16, epc16;
    logic        pend16, redir16;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pc_next_unit dut32 (
        .clk(clk), .reset(reset), .iStall(stall), .iPCSrc(pcsrc), .iBranch(branch),
        .iJumpTgt(jtgt), .iJumpReg(jreg), .iBranchTarget(btgt), .iIntReq(intreq),
        .oPC(pc32), .oPC_plus_4(pc4_32), .oEPC(epc32), .oIntPending(pend32), .oRedirect(redir32)
    );

    pc_next_unit #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .iStall(stall), .iPCSrc(pcsrc), .iBranch(branch),
        .iJumpTgt(jtgt[15:0]), .iJumpReg(jreg[15:0]), .iBranchTarget(btgt[15:0]), .iIntReq(intreq),
        .oPC(pc16), .oPC_plus_4(pc4_16), .oEPC(epc16), .oIntPending(pend16), .oRedirect(redir16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; pcsrc = 3'b000; branch = 1'b0;
        jtgt = '0; jreg = '0; btgt = '0; intreq = 1'b0;
        step(); step();
        check("rst_pc", pc32, 32'h8000_0000);
        check("rst_epc", epc32, 32'h0);
        check("rst_pend", {31'b0, pend32}, 32'h0);
        check("rst_redir", {31'b0, redir32}, 32'h0);
        check("rst_pc16", {16'b0, pc16}, 32'h0);

        // T1 sequential fetch
        reset = 1'b0;
        step(); check("t1_pc1", pc32, 32'h8000_0004);
        step(); check("t1_pc2", pc32, 32'h8000_0008);
        step(); check("t1_pc3", pc32, 32'h8000_000C);
        check("t1_redir", {31'b0, redir32}, 32'h0);
        check("t1_plus4", pc4_32, 32'h8000_0010);

        // T2 branch not taken / taken, then jr and a reserved encoding
        pcsrc = 3'b001; jtgt = 32'h100;
        step(); check("t2_j", pc32, 32'h100);
        check("t2_j_redir", {31'b0, redir32}, 32'h1);
        pcsrc = 3'b100; branch = 1'b0; btgt = 32'h200;
        step(); check("t2_bnt", pc32, 32'h104);
        check("t2_bnt_redir", {31'b0, redir32}, 32'h0);
        branch = 1'b1;
        step(); check("t2_bt", pc32, 32'h200);
        check("t2_bt_redir", {31'b0, redir32}, 32'h1);
        pcsrc = 3'b000; branch = 1'b0;
        step(); check("t2_seq", pc32, 32'h204);
        check("t2_redir_drop", {31'b0, redir32}, 32'h0);
        pcsrc = 3'b010; jreg = 32'h500;
        step(); check("t2_jr", pc32, 32'h500);
        pcsrc = 3'b110;
        step(); check("t2_rsvd", pc32, 32'h504);

        // T3 jump buffered during a three-cycle stall
        stall = 1'b1; pcsrc = 3'b001; jtgt = 32'h400;
        step(); check("t3_hold1", pc32, 32'h504);
        pcsrc = 3'b000;
        step(); check("t3_hold2", pc32, 32'h504);
        step(); check("t3_hold3", pc32, 32'h504);
        check("t3_hold_redir", {31'b0, redir32}, 32'h0);
        stall = 1'b0;
        step(); check("t3_release", pc32, 32'h400);
        check("t3_redir", {31'b0, redir32}, 32'h1);

        // T4 exception replaces buffered jump
        stall = 1'b1; pcsrc = 3'b001; jtgt = 32'h600;
        step();
        pcsrc = 3'b011;
        step(); check("t4_hold", pc32, 32'h400);
        stall = 1'b0; pcsrc = 3'b000;
        step(); check("t4_pc", pc32, 32'h8000_0008);
        check("t4_epc", epc32, 32'h400);

        // T5 interrupt latched through a stall
        pcsrc = 3'b001; jtgt = 32'h300;
        step(); check("t5_pc", pc32, 32'h300);
        pcsrc = 3'b000; stall = 1'b1; intreq = 1'b1;
        step(); check("t5_pend1", {31'b0, pend32}, 32'h1);
        intreq = 1'b0;
        step(); check("t5_pend2", {31'b0, pend32}, 32'h1);
        check("t5_hold", pc32, 32'h300);
        stall = 1'b0;
        step(); check("t5_int_pc", pc32, 32'h8000_0004);
        check("t5_epc", epc32, 32'h304);
        check("t5_pend_clr", {31'b0, pend32}, 32'h0);

        // New request in the same cycle as a take stays pending
        intreq = 1'b1;
        step(); check("ir_seq", pc32, 32'h8000_0008);
        check("ir_pend", {31'b0, pend32}, 32'h1);
        step(); check("ir_take", pc32, 32'h8000_0004);
        check("ir_epc", epc32, 32'h8000_000C);
        check("ir_keep", {31'b0, pend32}, 32'h1);
        intreq = 1'b0;
        step(); check("ir_take2", pc32, 32'h8000_0004);
        check("ir_epc2", epc32, 32'h8000_0008);
        check("ir_clr", {31'b0, pend32}, 32'h0);

        // T6 wrap at both widths, then reset while a redirect is buffered
        pcsrc = 3'b001; jtgt = 32'hFFFF_FFFC;
        step(); check("t6_pc16", {16'b0, pc16}, 32'hFFFC);
        pcsrc = 3'b000;
        step(); check("t6_wrap16", {16'b0, pc16}, 32'h0);
        check("t6_wrap32", pc32, 32'h0);
        stall = 1'b1; pcsrc = 3'b001; jtgt = 32'h1234;
        step(); check("t6_hold16", {16'b0, pc16}, 32'h0);
        pcsrc = 3'b000; reset = 1'b1;
        step(); check("t6_rst32", pc32, 32'h8000_0000);
        check("t6_rst16", {16'b0, pc16}, 32'h0);
        reset = 1'b0; stall = 1'b0;
        step(); check("t6_rel32", pc32, 32'h8000_0004);
        check("t6_rel16", {16'b0, pc16}, 32'h4);
        check("t6_noredir", {31'b0, redir32}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
